// File: rtl/mem_stage_vl_pkg.sv
// Shared bus widths, bus layouts and load-alignment helpers for the
// variable-latency memory stage.
package mem_stage_vl_pkg;

  localparam int ES_TO_MS_BUS_WD = 72;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int ES_EX_BUS_WD    = 10;
  localparam int MS_EX_BUS_WD    = 10;

  // width field of es_load_mem_bus; any other code is a full word
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_BYTE = 2'b01;
  localparam logic [1:0] LD_HALF = 2'b10;

  typedef struct packed {
    logic        mem_req;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  // lr[3] selects lwl, lr[2] selects lwr
  typedef struct packed {
    logic [1:0] width;
    logic       sign;
    logic       lwl;
    logic       lwr;
    logic [1:0] offset;
  } load_ctl_t;

  typedef struct packed {
    logic       bd;
    logic       sys;
    logic       mfc0;
    logic       mtc0;
    logic       eret;
    logic [4:0] addr;
  } ex_t;

  function automatic logic [31:0] load_align(input load_ctl_t c, input logic [31:0] rdata);
    logic [63:0] dbl;
    logic [7:0]  b;
    logic [15:0] h;
    logic [5:0]  sh;
    dbl = {rdata, rdata};
    sh  = {1'b0, c.offset, 3'b000};
    b   = 8'(rdata >> sh);
    h   = c.offset[1] ? rdata[31:16] : rdata[15:0];
    if (c.lwl)                  load_align = 32'(dbl >> (sh + 6'd8));
    else if (c.lwr)             load_align = 32'(dbl >> sh);
    else if (c.width == LD_BYTE) load_align = {{24{c.sign & b[7]}}, b};
    else if (c.width == LD_HALF) load_align = {{16{c.sign & h[15]}}, h};
    else                        load_align = rdata;
  endfunction

  function automatic logic [3:0] load_we(input load_ctl_t c, input logic gr_we);
    logic [3:0] lwl_we;
    logic [3:0] lwr_we;
    lwl_we = 4'b1111 << (2'd3 - c.offset);
    lwr_we = 4'b1111 >> c.offset;
    if (c.lwl)      load_we = lwl_we;
    else if (c.lwr) load_we = lwr_we;
    else            load_we = {4{gr_we}};
  endfunction

endpackage

// File: rtl/mem_stage_vl_resp_fifo.sv
// Circular response buffer holding read data that returned before the
// owning load could leave MS.
module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      assert (!(push && !pop && count == CW'(DEPTH))) else $error("resp_fifo overflow");
      assert (!(pop && count == '0)) else $error("resp_fifo underflow");
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_stage_vl.sv
// Variable-latency MEM stage: tracks outstanding data requests, drops
// responses of flushed loads and buffers early responses until WB accepts.
module mem_stage_vl
  import mem_stage_vl_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [6:0]                 es_load_mem_bus,
  input  logic [ES_EX_BUS_WD-1:0]    es_ex_bus,
  input  logic                       es_req_issue,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_EX_BUS_WD-1:0]    ms_ex_bus,
  output logic [35:0]                ms_to_ds_bus,
  output logic                       ms_write_reg,
  output logic [4:0]                 ms_reg_dest,
  output logic                       ms_data_stall,
  output logic                       ms_mfc0_stall,
  output logic                       ms_ex,
  output logic                       ms_mem_full
);

  logic        ms_valid;
  es_to_ms_t   ms_r;
  load_ctl_t   ld_r;
  ex_t         ex_r;

  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      fifo_head;
  logic             fifo_nonempty;
  logic             drop_zero;
  logic             accept;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             ms_ready_go;
  logic             ms_xfer;
  logic [31:0]      rdata_sel;
  logic [31:0]      final_result;
  logic [3:0]       reg_we;
  load_ctl_t        ld_eff;

  // pipeline register
  always_ff @(posedge clk) begin
    if (reset || flush) ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;

    if (reset) begin
      ms_r <= '0;
      ld_r <= '0;
      ex_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      ms_r <= es_to_ms_t'(es_to_ms_bus);
      ld_r <= load_ctl_t'(es_load_mem_bus);
      ex_r <= ex_t'(es_ex_bus);
    end
  end

  // outst counts requests at the SRAM; drop counts those owned by flushed work
  always_ff @(posedge clk) begin
    if (reset) begin
      outst <= '0;
      drop  <= '0;
    end else begin
      outst <= CNT_W'({1'b0, outst} + (CNT_W+1)'(es_req_issue) - (CNT_W+1)'(data_sram_data_ok));
      if (flush)
        drop <= CNT_W'({1'b0, outst} + (CNT_W+1)'(es_req_issue) - (CNT_W+1)'(data_sram_data_ok));
      else if (data_sram_data_ok && !drop_zero)
        drop <= drop - 1'b1;
    end
  end

  assign drop_zero     = (drop == '0);
  assign fifo_nonempty = (fifo_cnt != '0);
  assign accept        = data_sram_data_ok & drop_zero & !flush;

  assign ms_ready_go    = !ms_r.mem_req | fifo_nonempty | (data_sram_data_ok & drop_zero);
  assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign ms_xfer        = ms_to_ws_valid & ws_allowin;

  // zero-wait responses bypass the buffer straight into WB
  assign bypass    = accept & !fifo_nonempty & ms_r.mem_req & ms_xfer;
  assign fifo_push = accept & !bypass;
  assign fifo_pop  = ms_xfer & ms_r.mem_req & fifo_nonempty;

  resp_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (32)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .din   (data_sram_rdata),
    .head  (fifo_head),
    .count (fifo_cnt)
  );

  always_comb begin
    ld_eff       = ld_r;
    ld_eff.lwl   = ld_r.lwl & ms_r.res_from_mem;
    ld_eff.lwr   = ld_r.lwr & ms_r.res_from_mem;
    rdata_sel    = fifo_nonempty ? fifo_head : data_sram_rdata;
    reg_we       = load_we(ld_eff, ms_r.gr_we);
    final_result = ms_r.res_from_mem ? load_align(ld_eff, rdata_sel) : ms_r.alu_result;
  end

  assign ms_to_ws_bus  = {reg_we, ms_r.dest, final_result, ms_r.pc};
  assign ms_ex_bus     = ex_r;
  assign ms_to_ds_bus  = {final_result, reg_we};
  assign ms_write_reg  = ms_valid & ms_r.gr_we;
  assign ms_reg_dest   = ms_r.dest;
  assign ms_data_stall = ms_valid & ms_r.res_from_mem & !ms_ready_go;
  assign ms_mfc0_stall = ms_valid & ex_r.mfc0;
  assign ms_ex         = ms_valid & (ex_r.eret | ex_r.sys);
  assign ms_mem_full   = ({1'b0, outst} + {1'b0, fifo_cnt}) >= (CNT_W+1)'(MAX_OUTST);

endmodule
